mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Responder end of the cache_control interface: the single agent that answers icache and dcache word requests and drives the one shared RAM port.
- Arbitrates between the two initiators, holds the grant for one whole word transaction, and returns dwait/iwait and load data.
- Data side has priority; a starvation counter guarantees instruction forward progress.

Parameters:
- STARVE_LIMIT, 4: consecutive data completions allowed while iREN is pending before instruction side is forced next; legal range 1..15.

Ports:
- CLK  input  1  clock, rising edge
- nRST  input  1  asynchronous active-low reset
- iREN  input  1  instruction read request
- iaddr  input  32  instruction word address
- iwait  output  1  1 = instruction request not complete
- iload  output  32  instruction read data
- dREN  input  1  data read request
- dWEN  input  1  data write request
- daddr  input  32  data word address
- dstore  input  32  data write value
- dwait  output  1  1 = data request not complete
- dload  output  32  data read data
- ramREN  output  1  RAM read strobe
- ramWEN  output  1  RAM write strobe
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data
- ramstate  input  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR

Behaviour:
- Reset:
  - Async on nRST low: state IDLE, starve count 0.
  - During reset: iwait=dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0.
  - Reset mid-transaction abandons it; no completion is reported.
- FSM states: IDLE, DGRANT, IGRANT (registered).
- IDLE:
  - Drives no RAM strobes; both waits are 1.
  - Next state: DGRANT if (dREN|dWEN) and not forced, else IGRANT if iREN, else IDLE.
  - Forced means iREN=1 and starve count == STARVE_LIMIT; a forced arbitration selects IGRANT even if the data side requests.
- DGRANT:
  - ramaddr=daddr; ramstore=dstore; ramWEN=dWEN; ramREN=dREN&~dWEN (write wins when both are set).
  - dload=ramload; iload=0.
  - dwait=0 only in a cycle where ramstate==ACCESS; otherwise 1.
- IGRANT:
  - ramaddr=iaddr; ramREN=1; ramWEN=0; ramstore=0.
  - iload=ramload; dload=0.
  - iwait=0 only when ramstate==ACCESS.
- Completion (ramstate==ACCESS in a grant state):
  - The wait drop is combinational, exactly one cycle per word.
  - Next state is IDLE, so there is one dead cycle between transactions.
  - Minimum request-to-completion latency is 2 cycles: request at t0, grant at t1, ACCESS at t1 earliest.
- Withdrawal: if the granted side deasserts all of its request lines before completion, go to IDLE next cycle with no completion and no counter change.
- ERROR or BUSY: treated as not-yet-complete; grant, strobes and address are held.
- Initiator rule: address, data and strobes are stable while wait=1. The arbiter does not latch them; it passes them through.
- Starve counter:
  - +1 on each data completion while iREN=1, saturating at STARVE_LIMIT.
  - Cleared on an instruction completion or in any cycle with iREN=0.
- Non-granted side always sees wait=1 and load=0.
- Both strobes are never asserted to RAM in the same cycle; the arbiter never drives RAM in IDLE.

Test Plan:
- Reset: nRST low mid-DGRANT with ramstate=BUSY -> same cycle ramWEN/ramREN=0, dwait=1; after release, FSM in IDLE and counter 0.
- Instruction read: iREN=1, iaddr=0x40; RAM gives ACCESS 2 cycles after grant with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40 from grant; iwait=0 and iload=0xDEADBEEF for exactly one cycle; IDLE next.
- Data write priority: iREN, dWEN both high in IDLE, daddr=0x80, dstore=0x12345678 -> DGRANT, ramWEN=1, ramstore=0x12345678, iwait stays 1; IGRANT follows after completion plus the dead cycle.
- dREN and dWEN asserted together -> ramWEN=1, ramREN=0.
- Starvation: iREN held, dREN re-asserted continuously, STARVE_LIMIT=4 -> exactly 4 data completions, then IGRANT even with dREN=1; counter reads 0 after the instruction completion.
- Withdrawal and error: in DGRANT, ramstate=ERROR for 3 cycles keeps dwait=1 and strobes held; then dREN dropped -> IDLE next cycle, no dwait=0 pulse, counter unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Responder end of the cache_control interface. It answers the instruction
// cache and data cache word requests and drives the single shared RAM port.
// One word transaction owns the RAM from grant to completion. The data side
// wins contested arbitrations. A starvation counter forces an instruction
// grant after STARVE_LIMIT back-to-back data completions while an
// instruction read is waiting.
//
// Parameters
//   STARVE_LIMIT  data completions tolerated while iREN waits (1..15)
//
// Ports
//   CLK       in   clock, rising edge
//   nRST      in   asynchronous active-low reset
//   iREN      in   instruction read request
//   iaddr     in   instruction word address
//   iwait     out  1 = instruction request not complete
//   iload     out  instruction read data
//   dREN      in   data read request
//   dWEN      in   data write request
//   daddr     in   data word address
//   dstore    in   data write value
//   dwait     out  1 = data request not complete
//   dload     out  data read data
//   ramREN    out  RAM read strobe
//   ramWEN    out  RAM write strobe
//   ramaddr   out  RAM address
//   ramstore  out  RAM write data
//   ramload   in   RAM read data
//   ramstate  in   0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    // instruction initiator
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    // data initiator
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    // shared RAM port
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] starve_q, starve_d;

    logic d_req;
    logic ram_access;
    logic forced;

    assign d_req      = dREN | dWEN;
    assign ram_access = (ramstate == RAM_ACCESS);
    // The instruction side takes the next grant regardless of data requests
    // once it has watched LIMIT data words go by.
    assign forced     = iREN && (starve_q == LIMIT);

    // -------------------------------------------------------------------------
    // State and starvation counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state, counter update and all outputs
    //
    // Outputs are combinational from the registered grant so the wait drop
    // coincides with the RAM ACCESS cycle. Nothing is latched: the initiators
    // hold address/data/strobes stable while their wait is high.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;

        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;

        unique case (state_q)
            IDLE: begin
                if (d_req && !forced) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end
            end

            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                // Write wins when both strobes are raised, so the RAM never
                // sees REN and WEN together.
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dload    = ramload;

                if (!d_req) begin
                    // Withdrawn before completion: release without reporting.
                    state_d = IDLE;
                end else if (ram_access) begin
                    dwait   = 1'b0;
                    state_d = IDLE;
                    if (iREN && (starve_q < LIMIT)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end

            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                iload   = ramload;

                if (!iREN) begin
                    state_d = IDLE;
                end else if (ram_access) begin
                    iwait    = 1'b0;
                    state_d  = IDLE;
                    starve_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Nobody is waiting on the instruction side, so nothing is starving.
        if (!iREN) begin
            starve_d = '0;
        end
    end

endmodule
